mem_access_unit: RTL and testbench

- Memory stage directly downstream of the integer/address unit; consumes its 32-bit result (zero-extended immediate or register+immediate) as an effective address or pass-through value.
- Performs word loads/stores against data memory over a req/ack handshake, with a bounded wait, alignment check and registered writeback outputs.
- Upstream and downstream are decoupled by valid/ready; one transaction in flight at a time.

---
 rtl/mem_access_unit_pkg.sv | 14 +
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit_timeout_ctr.sv | 18 +
 rtl/mem_access_unit.sv | 89 ++++++++
 tb/tb_mem_access_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: opcode/state encodings and widths shared with the address unit
package mem_access_unit_pkg;
    localparam int BITSOUT_DEF = 32;
    localparam int REGADDR_DEF = 4;
    localparam int MEMOP_DEF = 2;
    localparam int TIMEOUT_DEF = 16;
    localparam logic [1:0] OP_PASS = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: upstream, data-memory and writeback signals of the memory stage
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int BITSOUT = BITSOUT_DEF,
    parameter int REGADDR = REGADDR_DEF,
    parameter int MEMOP = MEMOP_DEF
);
    logic inValid;
    logic inReady;
    logic [MEMOP-1:0] memOP;
    logic [BITSOUT-1:0] address;
    logic [BITSOUT-1:0] storeData;
    logic [REGADDR-1:0] destReg;
    logic memReq;
    logic memWe;
    logic [BITSOUT-1:0] memAddr;
    logic [BITSOUT-1:0] memWData;
    logic memAck;
    logic [BITSOUT-1:0] memRData;
    logic outValid;
    logic outReady;
    logic [BITSOUT-1:0] outData;
    logic [REGADDR-1:0] outDest;
    logic outWbEn;
    logic outErr;
    modport slave (
        input inValid, memOP, address, storeData, destReg, memAck, memRData, outReady,
        output inReady, memReq, memWe, memAddr, memWData, outValid, outData, outDest, outWbEn, outErr
    );
    modport master (
        output inValid, memOP, address, storeData, destReg, memAck, memRData, outReady,
        input inReady, memReq, memWe, memAddr, memWData, outValid, outData, outDest, outWbEn, outErr
    );
endinterface

// File: rtl/mem_access_unit_timeout_ctr.sv
// mem_timeout_ctr: counts ISSUE cycles and flags the last one allowed before giving up
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16,
    localparam int CW = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [CW-1:0] r_count;
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) r_count <= '0;
        else if (i_enable) r_count <= r_count + CW'(1);
    end
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: word load/store stage with bounded memory wait and registered writeback
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int BITSOUT = BITSOUT_DEF,
    parameter int REGADDR = REGADDR_DEF,
    parameter int MEMOP = MEMOP_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clk,
    input logic rst_n,
    mem_access_unit_if.slave io_bus
);
    logic [1:0] r_state;
    logic r_memReq;
    logic r_memWe;
    logic [BITSOUT-1:0] r_memAddr;
    logic [BITSOUT-1:0] r_memWData;
    logic [BITSOUT-1:0] r_outData;
    logic [REGADDR-1:0] r_outDest;
    logic r_outWbEn;
    logic r_outErr;
    logic [MEMOP-1:0] w_op;
    logic w_accept;
    logic w_go_mem;
    logic w_expired;
    assign w_op = io_bus.memOP;
    assign w_accept = io_bus.inValid && io_bus.inReady;
    assign w_go_mem = (w_op == OP_LOAD || w_op == OP_STORE) && io_bus.address[1:0] == 2'b00;
    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk(clk),
        .rst_n(rst_n),
        .i_clear(r_state != ST_ISSUE),
        .i_enable(r_state == ST_ISSUE),
        .o_expired(w_expired)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_memReq <= 1'b0;
            r_memWe <= 1'b0;
            r_memAddr <= '0;
            r_memWData <= '0;
            r_outData <= '0;
            r_outDest <= '0;
            r_outWbEn <= 1'b0;
            r_outErr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_outDest <= io_bus.destReg;
                    if (w_go_mem) begin
                        r_state <= ST_ISSUE;
                        r_memReq <= 1'b1;
                        r_memWe <= w_op == OP_STORE;
                        r_memAddr <= io_bus.address;
                        r_memWData <= w_op == OP_STORE ? io_bus.storeData : '0;
                    end else begin
                        // pass-through succeeds; reserved and misaligned ops end here as errors
                        r_state <= ST_RESP;
                        r_outData <= w_op == OP_PASS ? io_bus.address : '0;
                        r_outWbEn <= w_op == OP_PASS;
                        r_outErr <= w_op != OP_PASS;
                    end
                end
                ST_ISSUE: if (io_bus.memAck || w_expired) begin
                    // an ack on the final allowed cycle still completes normally
                    r_state <= ST_RESP;
                    r_memReq <= 1'b0;
                    r_outData <= io_bus.memAck && !r_memWe ? io_bus.memRData : '0;
                    r_outWbEn <= io_bus.memAck && !r_memWe;
                    r_outErr <= !io_bus.memAck;
                end
                ST_RESP: if (io_bus.outReady) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign io_bus.inReady = rst_n && r_state == ST_IDLE;
    assign io_bus.outValid = r_state == ST_RESP;
    assign io_bus.memReq = r_memReq;
    assign io_bus.memWe = r_memWe;
    assign io_bus.memAddr = r_memAddr;
    assign io_bus.memWData = r_memWData;
    assign io_bus.outData = r_outData;
    assign io_bus.outDest = r_outDest;
    assign io_bus.outWbEn = r_outWbEn;
    assign io_bus.outErr = r_outErr;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for the memory access stage
module tb_mem_access_unit;
    typedef struct {
        logic [31:0] data;
        logic [3:0] dest;
        logic wben;
        logic err;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int req_total = 0;
    int lat;
    int snap;
    exp_t sb[$];
    mem_access_unit_if #(.BITSOUT(32), .REGADDR(4), .MEMOP(2)) bus ();
    mem_access_unit #(.BITSOUT(32), .REGADDR(4), .MEMOP(2), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) req_total <= req_total + int'(bus.memReq);
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] sd, input logic [3:0] dest);
        bus.inValid = 1'b1;
        bus.memOP = op;
        bus.address = addr;
        bus.storeData = sd;
        bus.destReg = dest;
        @(negedge clk);
        bus.inValid = 1'b0;
    endtask
    task automatic expect_out(input logic [31:0] data, input logic [3:0] dest, input logic wben, input logic err);
        exp_t e;
        e.data = data;
        e.dest = dest;
        e.wben = wben;
        e.err = err;
        sb.push_back(e);
    endtask
    task automatic mem_resp(input string tag, input int delay, input logic [31:0] data);
        repeat (delay - 1) begin
            check({tag, ":req_hold"}, 32'(bus.memReq), 32'd1);
            @(negedge clk);
        end
        bus.memAck = 1'b1;
        bus.memRData = data;
        @(negedge clk);
        bus.memAck = 1'b0;
        bus.memRData = 32'h0;
    endtask
    task automatic wait_out(input string tag, input int budget, output int l);
        exp_t e;
        l = 0;
        while (bus.outValid !== 1'b1 && l < budget) begin
            @(negedge clk);
            l++;
        end
        check({tag, ":outValid"}, 32'(bus.outValid), 32'd1);
        if (bus.outValid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ":outData"}, bus.outData, e.data);
            check({tag, ":outDest"}, 32'(bus.outDest), 32'(e.dest));
            check({tag, ":outWbEn"}, 32'(bus.outWbEn), 32'(e.wben));
            check({tag, ":outErr"}, 32'(bus.outErr), 32'(e.err));
        end
        bus.outReady = 1'b1;
        @(negedge clk);
        check({tag, ":drain"}, 32'(bus.outValid), 32'd0);
        check({tag, ":inReady"}, 32'(bus.inReady), 32'd1);
    endtask
    initial begin
        bus.inValid = 1'b0;
        bus.memOP = 2'd0;
        bus.address = 32'h0;
        bus.storeData = 32'h0;
        bus.destReg = 4'h0;
        bus.memAck = 1'b0;
        bus.memRData = 32'h0;
        bus.outReady = 1'b1;
        repeat (2) @(negedge clk);
        check("rst:memReq", 32'(bus.memReq), 32'd0);
        check("rst:outValid", 32'(bus.outValid), 32'd0);
        check("rst:inReady", 32'(bus.inReady), 32'd0);
        check("rst:outData", bus.outData, 32'h0);
        check("rst:memAddr", bus.memAddr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle:inReady", 32'(bus.inReady), 32'd1);
        snap = req_total;
        expect_out(32'h0000_1234, 4'd5, 1'b1, 1'b0);
        send(2'd0, 32'h0000_1234, 32'h0, 4'd5);
        wait_out("pass", 4, lat);
        check("pass:latency", 32'(lat), 32'd0);
        check("pass:no_req", 32'(req_total - snap), 32'd0);
        snap = req_total;
        expect_out(32'hDEAD_BEEF, 4'd6, 1'b1, 1'b0);
        send(2'd1, 32'h0000_0100, 32'h1111_1111, 4'd6);
        check("load:memAddr", bus.memAddr, 32'h0000_0100);
        check("load:memWe", 32'(bus.memWe), 32'd0);
        check("load:memWData", bus.memWData, 32'h0);
        mem_resp("load", 3, 32'hDEAD_BEEF);
        check("load:req_drop", 32'(bus.memReq), 32'd0);
        wait_out("load", 4, lat);
        check("load:latency", 32'(lat), 32'd0);
        check("load:req_cycles", 32'(req_total - snap), 32'd3);
        bus.outReady = 1'b0;
        expect_out(32'h0, 4'd3, 1'b0, 1'b0);
        send(2'd2, 32'h0000_0204, 32'hCAFE_F00D, 4'd3);
        check("store:memWe", 32'(bus.memWe), 32'd1);
        check("store:memWData", bus.memWData, 32'hCAFE_F00D);
        check("store:memAddr", bus.memAddr, 32'h0000_0204);
        check("store:inReady", 32'(bus.inReady), 32'd0);
        mem_resp("store", 1, 32'h9999_9999);
        for (int i = 0; i < 4; i++) begin
            check("store:bp_valid", 32'(bus.outValid), 32'd1);
            check("store:bp_inReady", 32'(bus.inReady), 32'd0);
            check("store:bp_wben", 32'(bus.outWbEn), 32'd0);
            @(negedge clk);
        end
        wait_out("store", 4, lat);
        snap = req_total;
        expect_out(32'h0, 4'd7, 1'b0, 1'b1);
        send(2'd1, 32'h0000_0102, 32'h0, 4'd7);
        wait_out("misalign", 4, lat);
        check("misalign:latency", 32'(lat), 32'd0);
        expect_out(32'h0, 4'd8, 1'b0, 1'b1);
        send(2'd3, 32'h0000_0200, 32'h0, 4'd8);
        wait_out("rsvd", 4, lat);
        check("err:no_req", 32'(req_total - snap), 32'd0);
        snap = req_total;
        expect_out(32'h0, 4'd9, 1'b0, 1'b1);
        send(2'd1, 32'h0000_0300, 32'h0, 4'd9);
        wait_out("timeout", 40, lat);
        check("timeout:latency", 32'(lat), 32'd16);
        check("timeout:req_cycles", 32'(req_total - snap), 32'd16);
        snap = req_total;
        expect_out(32'h5555_AAAA, 4'd10, 1'b1, 1'b0);
        send(2'd1, 32'h0000_0304, 32'h0, 4'd10);
        mem_resp("ack16", 16, 32'h5555_AAAA);
        wait_out("ack16", 4, lat);
        check("ack16:latency", 32'(lat), 32'd0);
        check("ack16:req_cycles", 32'(req_total - snap), 32'd16);
        send(2'd2, 32'h0000_0400, 32'h7777_7777, 4'd11);
        @(negedge clk);
        check("midrst:req_before", 32'(bus.memReq), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst:memReq", 32'(bus.memReq), 32'd0);
        check("midrst:memWe", 32'(bus.memWe), 32'd0);
        check("midrst:memAddr", bus.memAddr, 32'h0);
        check("midrst:memWData", bus.memWData, 32'h0);
        check("midrst:outValid", 32'(bus.outValid), 32'd0);
        check("midrst:outData", bus.outData, 32'h0);
        check("midrst:outDest", 32'(bus.outDest), 32'd0);
        rst_n = 1'b1;
        bus.memAck = 1'b1;
        bus.memRData = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.memAck = 1'b0;
        check("lateack:outValid", 32'(bus.outValid), 32'd0);
        check("lateack:inReady", 32'(bus.inReady), 32'd1);
        @(negedge clk);
        check("lateack:outValid2", 32'(bus.outValid), 32'd0);
        check("sb:empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
